mm21_pixel_streamer: RTL
========================

Name: mm21_pixel_streamer

Overview:
Upstream feeder for the LED-matrix SPI master. It buffers pixel bytes from a pixel producer in a small FIFO and frames them for the SPI master. Each frame is sent as the reset-frame-index command byte, then exactly PIXELS_PER_FRAME pixel bytes. It drives the master's tx_valid/tx_ready/tx_byte/tx_clear_cs handshake, so the producer never has to know the matrix protocol.

Parameters:
FIFO_DEPTH, 4, pixel FIFO entries; power of two, at least 2
PIXELS_PER_FRAME, 64, pixel bytes per frame; at least 2
CMD_BYTE, 8'h26, reset-frame-index command byte sent at frame start

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  reset; asynchronous, active-low
in_valid  in  1  producer presents in_pixel
in_ready  out  1  FIFO can accept (not full)
in_pixel  in  8  RGB332 pixel byte
tx_ready  in  1  SPI master idle and able to accept a byte
tx_valid  out  1  tx_byte is valid
tx_byte  out  8  byte to transmit
tx_clear_cs  out  1  master deasserts CS after this byte
fifo_level  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy
frame_count  out  8  completed frames, modulo 256

Behaviour:
- Transfer rules: a producer push happens when in_valid && in_ready at a rising edge. A tx transfer happens when tx_valid && tx_ready at a rising edge.
- Handshake stability: once tx_valid is high, tx_valid, tx_byte and tx_clear_cs stay stable until the transfer.
- Reset (reset_n=0), effective immediately, no clock needed:
  - FIFO flushed; fifo_level=0; in_ready=1.
  - State IDLE; pixel counter 0; frame_count=0.
  - tx_valid=0, tx_byte=0, tx_clear_cs=0.
- FIFO:
  - in_ready = (fifo_level != FIFO_DEPTH).
  - When full, in_ready=0 even if a pop happens in the same cycle. No push-through.
  - Simultaneous push and pop when not full: level unchanged; data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, CMD, PIX:
  - IDLE:
    - tx_valid=0.
    - Goes to CMD on the edge where registered fifo_level != 0.
    - Latency: a push into an empty FIFO at edge N gives tx_valid=1 after edge N+1.
  - CMD:
    - tx_valid=1, tx_byte=CMD_BYTE, tx_clear_cs=1.
    - On transfer: go to PIX, pixel counter := 0.
  - PIX:
    - tx_valid = FIFO not empty; tx_byte = FIFO head.
    - tx_clear_cs = (pixel counter == PIXELS_PER_FRAME-1).
    - On transfer: pop the FIFO, increment the pixel counter.
    - If the transferred byte was the last pixel: go to IDLE, pixel counter := 0, frame_count += 1 (wraps 255 -> 0).
- Underrun inside PIX (FIFO empty):
  - tx_valid=0; stay in PIX; no command resent.
  - Master keeps CS asserted; transmission resumes with the next pushed byte.
- tx_ready high while tx_valid low: no effect.
- Counters: the pixel counter is clog2(PIXELS_PER_FRAME) bits and never exceeds PIXELS_PER_FRAME-1.
- Reset mid-frame discards buffered pixels. The next frame begins with CMD_BYTE.

Decomposition:
- Package mm21_led_pkg holds:
  - CMD_RESET_FRAME_INDEX (8'h26)
  - default PIXELS_PER_FRAME (64)
  - state encoding (IDLE=0, CMD=1, PIX=2)
- One sub-module, mm21_byte_fifo:
  - parameterised depth, 8-bit data, async active-low reset
  - ports: push/pop/full/empty/level/head
- The top holds the FSM, pixel counter and frame counter.

Test Plan:
- Async reset: drive reset_n=0 mid-operation with the clock stopped -> tx_valid=0, in_ready=1, fifo_level=0, frame_count=0 immediately.
- Full frame with tx_ready always 1: push 0x00..0x3F -> transferred bytes are 0x26 (tx_clear_cs=1), then 0x00..0x3F with tx_clear_cs=0, except 0x3F with tx_clear_cs=1; frame_count=1; state IDLE.
- Backpressure (FIFO_DEPTH=4): hold tx_ready=0 and offer 5 bytes -> in_ready=0 after 4 pushes; fifo_level=4; tx_byte=0x26 stable.
  - Then release tx_ready -> order 0x26, byte1..byte5 with no loss or duplication.
- Underrun: push 10 pixels, pause 20 cycles, push the remaining 54 -> tx_valid=0 during the pause, no second 0x26, 65 bytes total, single tx_clear_cs on pixel 64.
- Reset mid-frame: pull reset_n low after 30 pixels are transferred, release, push 64 pixels -> first transferred byte 0x26, then a complete 64-pixel frame; frame_count=1.
- Wrap (PIXELS_PER_FRAME=2): stream 256 frames -> frame_count returns to 0; every frame starts with 0x26.

Source files
------------

// File: rtl/mm21_led_pkg.sv
// Shared definitions for the LED-matrix pixel streamer.
//   CMD_RESET_FRAME_INDEX : command byte that opens every frame
//   PIXELS_PER_FRAME_DEF  : default frame length in pixel bytes
//   state_t               : framing FSM state encoding
//   tx_req_t              : byte request presented to the SPI master
package mm21_led_pkg;

  localparam logic [7:0] CMD_RESET_FRAME_INDEX = 8'h26;
  localparam int         PIXELS_PER_FRAME_DEF  = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_PIX  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       clear_cs;
    logic [7:0] data;
  } tx_req_t;

endpackage

// File: rtl/mm21_byte_fifo.sv
// Byte FIFO, power-of-two depth, first-word-fall-through head.
//   clock, reset_n : clock / async active-low reset (flushes contents)
//   push/push_data : write when not full
//   pop            : drop head when not empty
//   full/empty     : occupancy flags
//   level          : occupancy 0..DEPTH
//   head           : oldest entry (stale when empty)
module mm21_byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [7:0]    head
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  // Push is gated on the registered full flag, so a pop in the same
  // cycle never lets a write through into a full FIFO.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);  // depth is a power of two: natural wrap
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/mm21_pixel_streamer.sv
// Frames buffered pixel bytes for the LED-matrix SPI master: each frame is
// CMD_BYTE followed by PIXELS_PER_FRAME pixels, CS released after the last.
//   clock, reset_n         : clock / async active-low reset
//   in_valid/in_ready/in_pixel : producer push interface
//   tx_valid/tx_ready/tx_byte/tx_clear_cs : SPI master byte handshake
//   fifo_level             : pixel FIFO occupancy
//   frame_count            : completed frames, mod 256
module mm21_pixel_streamer
  import mm21_led_pkg::*;
#(
  parameter  int         FIFO_DEPTH       = 4,
  parameter  int         PIXELS_PER_FRAME = PIXELS_PER_FRAME_DEF,
  parameter  logic [7:0] CMD_BYTE         = CMD_RESET_FRAME_INDEX,
  localparam int         LW               = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_pixel,
  input  logic          tx_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_byte,
  output logic          tx_clear_cs,
  output logic [LW-1:0] fifo_level,
  output logic [7:0]    frame_count
);

  localparam int            CW   = $clog2(PIXELS_PER_FRAME);
  localparam logic [CW-1:0] LAST = CW'(PIXELS_PER_FRAME - 1);

  state_t        state, state_nxt;
  tx_req_t       tx_req;
  logic [CW-1:0] pix_cnt;
  logic          fifo_full, fifo_empty, fifo_pop, last_pix;
  logic [7:0]    fifo_head;

  mm21_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_valid),
    .push_data (in_pixel),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (fifo_head)
  );

  assign in_ready    = !fifo_full;
  assign last_pix    = (pix_cnt == LAST);
  assign tx_valid    = tx_req.valid;
  assign tx_byte     = tx_req.data;
  assign tx_clear_cs = tx_req.clear_cs;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Outputs depend only on state and FIFO head, so they hold still while
  // the master stalls; an empty FIFO in PIX simply drops tx_valid (underrun)
  // without leaving the frame.
  always_comb begin
    state_nxt = state;
    tx_req    = '0;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: if (fifo_level != '0) state_nxt = ST_CMD;
      ST_CMD: begin
        tx_req.valid    = 1'b1;
        tx_req.clear_cs = 1'b1;
        tx_req.data     = CMD_BYTE;
        if (tx_ready) state_nxt = ST_PIX;
      end
      ST_PIX: begin
        tx_req.valid    = !fifo_empty;
        tx_req.clear_cs = last_pix;
        tx_req.data     = fifo_head;
        if (!fifo_empty && tx_ready) begin
          fifo_pop = 1'b1;
          if (last_pix) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt     <= '0;
      frame_count <= '0;
    end else if (state == ST_CMD && tx_ready) begin
      pix_cnt <= '0;
    end else if (fifo_pop) begin
      if (last_pix) begin
        pix_cnt     <= '0;
        frame_count <= frame_count + 8'd1;
      end else begin
        pix_cnt <= pix_cnt + CW'(1);
      end
    end
  end

endmodule
